game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//   Top-level play sequencer for the Flappy Bird game. Owns the bird's row position,
//   the gravity tick, flap edge detection and the score, and drives the bounds checker's
//   key/gravity/top/bottom inputs. Consumes out_of_bounds and pipe collision to end a
//   round. Sits between the debounced player key and the LED-matrix display logic.
// PARAMETERS
//   ROWS         8   number of display rows the bird can occupy (row 0 = bottom)
//   TICK_DIV     25  clk cycles between gravity pulses while playing (>= 2)
//   DEATH_CYCLES 4   cycles spent in DYING before GAME_OVER (>= 1)
//   SCORE_W      4   score counter width
// PORTS
//   clk            in   1                 system clock
//   reset          in   1                 asynchronous, active-low reset
//   key            in   1                 player button, level, already synchronized
//   pipe_pass      in   1                 1-cycle pulse: bird cleared a pipe
//   collide        in   1                 level: bird overlaps a pipe
//   out_of_bounds  in   1                 pulse from bounds checker
//   flap           out  1                 1-cycle key rising edge, gated to PLAY (to bounds.key)
//   gravity        out  1                 1-cycle gravity tick (to bounds.gravity)
//   top            out  1                 bird_row == ROWS-1 (to bounds.top)
//   bottom         out  1                 bird_row == 0 (to bounds.bottom)
//   bounds_clr     out  1                 high in IDLE; drives bounds checker reset
//   bird_row       out  $clog2(ROWS)      current bird row
//   score          out  SCORE_W           pipes passed this round
//   playing        out  1                 state == PLAY
//   game_over      out  1                 state == GAME_OVER
// BEHAVIOUR
//   Reset (async assert, any time): state=IDLE, bird_row=ROWS/2, score=0, tick cnt=0,
//     key_q=0; flap=gravity=0, playing=game_over=0, bounds_clr=1.
//   Edge detect: key_q <= key every cycle; rise = key & ~key_q (all states).
//     flap = rise & (state==PLAY), combinational.
//   Tick: counter runs 0..TICK_DIV-1 only in PLAY, cleared otherwise; gravity=1 for the
//     one cycle counter==TICK_DIV-1 in PLAY. First gravity TICK_DIV cycles after PLAY entry.
//   bird_row (PLAY only, registered, visible next cycle):
//     flap & ~gravity -> +1, saturate at ROWS-1;  gravity & ~flap -> -1, saturate at 0;
//     both or neither -> hold. Held in DYING/GAME_OVER; forced to ROWS/2 in IDLE.
//   top/bottom combinational from bird_row in all states.
//   FSM:
//     IDLE      -> PLAY on rise; score<=0; that rise does not move the bird.
//     PLAY      -> DYING on out_of_bounds | collide (evaluated every PLAY cycle).
//     DYING     counts DEATH_CYCLES cycles, then -> GAME_OVER. Key ignored.
//     GAME_OVER -> IDLE on rise; score held until next IDLE->PLAY.
//   Score: +1 on pipe_pass in PLAY, saturate at 2^SCORE_W-1. pipe_pass in the same cycle
//     as out_of_bounds|collide: death wins, no increment. pipe_pass outside PLAY ignored.
//   Simultaneous rise and death in PLAY: go to DYING; row still updates per flap rule.
//   Held key: only one rise per press; no auto-repeat.
// TESTING  (ROWS=8, TICK_DIV=4, DEATH_CYCLES=2, SCORE_W=4)
//   Reset low mid-PLAY at row 6 -> same cycle state=IDLE, bird_row=4, score=0, bounds_clr=1.
//   IDLE, press key -> playing=1 next cycle, bird_row stays 4; gravity pulses every 4 clks,
//     row 4->3->2->1->0 then holds 0 with bottom=1.
//   PLAY, 5 separate presses between ticks from row 4 -> row saturates at 7, top=1;
//     key held high 10 cycles -> exactly one flap pulse.
//   flap coincident with gravity -> bird_row unchanged.
//   out_of_bounds pulse in PLAY -> DYING for 2 cycles, then game_over=1; press -> IDLE,
//     score retained; next press -> PLAY with score=0.
//   17 pipe_pass pulses -> score=15 (saturated); pipe_pass with collide same cycle ->
//     no increment, state=DYING.

Source files
------------

// File: rtl/game_controller.sv
// Flappy Bird play sequencer: bird row, gravity tick, flap edge detect, score and
// round state, feeding the bounds checker and the LED-matrix display.
module game_controller #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned TICK_DIV     = 25,
  parameter int unsigned DEATH_CYCLES = 4,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_i,
  input  logic                    pipe_pass_i,
  input  logic                    collide_i,
  input  logic                    out_of_bounds_i,
  output logic                    flap_o,
  output logic                    gravity_o,
  output logic                    top_o,
  output logic                    bottom_o,
  output logic                    bounds_clr_o,
  output logic [$clog2(ROWS)-1:0] bird_row_o,
  output logic [SCORE_W-1:0]      score_o,
  output logic                    playing_o,
  output logic                    game_over_o
);

  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned DIE_W  = $clog2(DEATH_CYCLES + 1);

  localparam logic [ROW_W-1:0]   ROW_TOP   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]   ROW_MID   = ROW_W'(ROWS / 2);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DIE_W-1:0]   DIE_LAST  = DIE_W'(DEATH_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DYING,
    S_OVER
  } state_e;

  state_e              state_q, state_d;
  logic                key_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [DIE_W-1:0]    die_q, die_d;

  logic rise;
  logic death;
  logic grav;
  logic flap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= 1'b0;
      tick_q  <= '0;
      row_q   <= ROW_MID;
      score_q <= '0;
      die_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_i;
      tick_q  <= tick_d;
      row_q   <= row_d;
      score_q <= score_d;
      die_q   <= die_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    row_d   = row_q;
    score_d = score_q;
    die_d   = '0;

    rise  = key_i & ~key_q;
    death = out_of_bounds_i | collide_i;
    grav  = (state_q == S_PLAY) && (tick_q == TICK_LAST);
    flap  = rise && (state_q == S_PLAY);

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        tick_d = grav ? '0 : tick_q + TICK_W'(1);
        // Simultaneous flap and gravity cancel out.
        if (flap && !grav && (row_q != ROW_TOP)) begin
          row_d = row_q + ROW_W'(1);
        end else if (grav && !flap && (row_q != '0)) begin
          row_d = row_q - ROW_W'(1);
        end
        if (death) begin
          state_d = S_DYING;
        end else if (pipe_pass_i && (score_q != SCORE_MAX)) begin
          score_d = score_q + SCORE_W'(1);
        end
      end
      S_DYING: begin
        if (die_q == DIE_LAST) begin
          state_d = S_OVER;
        end else begin
          die_d = die_q + DIE_W'(1);
        end
      end
      S_OVER: begin
        if (rise) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Recentre the bird as soon as the round returns to IDLE.
    if (state_d == S_IDLE) begin
      row_d = ROW_MID;
    end
  end

  assign flap_o       = flap;
  assign gravity_o    = grav;
  assign top_o        = (row_q == ROW_TOP);
  assign bottom_o     = (row_q == '0);
  assign bounds_clr_o = (state_q == S_IDLE);
  assign bird_row_o   = row_q;
  assign score_o      = score_q;
  assign playing_o    = (state_q == S_PLAY);
  assign game_over_o  = (state_q == S_OVER);

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed round scenarios plus random play, checked every
// cycle against an abstract game model, with literal checks pinning the model.
module tb_game_controller;

  localparam int ROWS         = 8;
  localparam int TICK_DIV     = 4;
  localparam int DEATH_CYCLES = 2;
  localparam int SCORE_W      = 4;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DYING = 2;
  localparam int M_OVER = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic pipe_pass = 1'b0;
  logic collide = 1'b0;
  logic oob = 1'b0;

  logic flap_o, gravity_o, top_o, bottom_o, bounds_clr_o, playing_o, game_over_o;
  logic [2:0] bird_row_o;
  logic [SCORE_W-1:0] score_o;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  game_controller #(
    .ROWS(ROWS),
    .TICK_DIV(TICK_DIV),
    .DEATH_CYCLES(DEATH_CYCLES),
    .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_i(key),
    .pipe_pass_i(pipe_pass),
    .collide_i(collide),
    .out_of_bounds_i(oob),
    .flap_o(flap_o),
    .gravity_o(gravity_o),
    .top_o(top_o),
    .bottom_o(bottom_o),
    .bounds_clr_o(bounds_clr_o),
    .bird_row_o(bird_row_o),
    .score_o(score_o),
    .playing_o(playing_o),
    .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract game model: mode, cycles since round start, row, score, dying time.
  int m_mode, m_row, m_score, m_cyc, m_die;
  bit m_key;

  always @(posedge clk or negedge rst_n) begin
    bit rise, grav, fl;
    if (!rst_n) begin
      m_mode = M_IDLE; m_row = ROWS / 2; m_score = 0; m_cyc = 0; m_die = 0; m_key = 1'b0;
    end else begin
      rise = key && !m_key;
      grav = (m_mode == M_PLAY) && (m_cyc % TICK_DIV == TICK_DIV - 1);
      fl   = rise && (m_mode == M_PLAY);
      case (m_mode)
        M_IDLE: begin
          m_row = ROWS / 2;
          if (rise) begin m_mode = M_PLAY; m_score = 0; m_cyc = 0; end
        end
        M_PLAY: begin
          if (fl && !grav) m_row = (m_row + 1 > ROWS - 1) ? ROWS - 1 : m_row + 1;
          if (grav && !fl) m_row = (m_row - 1 < 0) ? 0 : m_row - 1;
          m_cyc++;
          if (oob || collide) begin
            m_mode = M_DYING; m_die = 0;
          end else if (pipe_pass) begin
            m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
          end
        end
        M_DYING: begin
          m_die++;
          if (m_die == DEATH_CYCLES) m_mode = M_OVER;
        end
        default: begin
          if (rise) begin m_mode = M_IDLE; m_row = ROWS / 2; end
        end
      endcase
      m_key = key;
    end
  end

  always @(negedge clk) begin
    bit e_rise, e_play, e_grav;
    if (cmp_en) begin
      e_rise = key && !m_key;
      e_play = (m_mode == M_PLAY);
      e_grav = e_play && (m_cyc % TICK_DIV == TICK_DIV - 1);
      chk("m_flap", int'(flap_o), int'(e_rise && e_play));
      chk("m_gravity", int'(gravity_o), int'(e_grav));
      chk("m_row", int'(bird_row_o), m_row);
      chk("m_top", int'(top_o), int'(m_row == ROWS - 1));
      chk("m_bottom", int'(bottom_o), int'(m_row == 0));
      chk("m_clr", int'(bounds_clr_o), int'(m_mode == M_IDLE));
      chk("m_score", int'(score_o), m_score);
      chk("m_playing", int'(playing_o), int'(e_play));
      chk("m_over", int'(game_over_o), int'(m_mode == M_OVER));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    key = 1'b1; step();
    key = 1'b0; step();
  endtask

  task automatic pass_pulse();
    pipe_pass = 1'b1; step();
    pipe_pass = 1'b0; step();
  endtask

  initial begin
    int nflap, r;
    bit saw, found;

    rst_n = 1'b0;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_clr", int'(bounds_clr_o), 1);
    chk("rst_row", int'(bird_row_o), 4);
    chk("rst_score", int'(score_o), 0);
    chk("rst_playing", int'(playing_o), 0);
    chk("rst_gravity", int'(gravity_o), 0);
    rst_n = 1'b1; step();

    // Start a round; the starting press must not move the bird.
    key = 1'b1; step(); key = 1'b0;
    chk("start_playing", int'(playing_o), 1);
    chk("start_row", int'(bird_row_o), 4);
    repeat (24) step();
    chk("fall_row", int'(bird_row_o), 0);
    chk("fall_bottom", int'(bottom_o), 1);

    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key = ~key; step();
      if (top_o && bird_row_o == 3'd7) saw = 1'b1;
    end
    chk("climb_top", int'(saw), 1);
    key = 1'b0; step(); step();

    nflap = 0;
    key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1; nflap += int'(flap_o);
      step();
    end
    key = 1'b0; step();
    chk("held_one_flap", nflap, 1);

    // Land a flap exactly on a gravity tick.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (gravity_o) found = 1'b1; else step();
    end
    chk("wait_gravity", int'(found), 1);
    step(); step(); step(); step();
    key = 1'b1; #1;
    chk("coin_flap", int'(flap_o), 1);
    chk("coin_gravity", int'(gravity_o), 1);
    r = int'(bird_row_o);
    step(); key = 1'b0;
    chk("coin_hold", int'(bird_row_o), r);

    repeat (3) pass_pulse();
    chk("score3", int'(score_o), 3);

    oob = 1'b1; step(); oob = 1'b0;
    chk("dying1_playing", int'(playing_o), 0);
    chk("dying1_over", int'(game_over_o), 0);
    step();
    chk("dying2_over", int'(game_over_o), 0);
    step();
    chk("over", int'(game_over_o), 1);
    pass_pulse();
    chk("over_score", int'(score_o), 3);
    press();
    chk("idle_score", int'(score_o), 3);
    chk("idle_clr", int'(bounds_clr_o), 1);
    chk("idle_row", int'(bird_row_o), 4);
    press();
    chk("replay_playing", int'(playing_o), 1);
    chk("replay_score", int'(score_o), 0);

    repeat (5) pass_pulse();
    chk("score5", int'(score_o), 5);
    pipe_pass = 1'b1; collide = 1'b1; step();
    pipe_pass = 1'b0; collide = 1'b0;
    chk("collide_score", int'(score_o), 5);
    chk("collide_playing", int'(playing_o), 0);
    repeat (4) step();
    press(); press();
    chk("round3_playing", int'(playing_o), 1);
    repeat (17) pass_pulse();
    chk("score_sat", int'(score_o), 15);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) key = ~key;
      pipe_pass = ($urandom_range(0, 5) == 0);
      collide   = ($urandom_range(0, 40) == 0);
      oob       = ($urandom_range(0, 40) == 0);
      step();
    end
    key = 1'b0; pipe_pass = 1'b0; collide = 1'b0; oob = 1'b0;
    step();

    // Return to PLAY, climb to row 6, then reset mid-cycle.
    for (int i = 0; i < 20 && !playing_o; i++) press();
    chk("pre_rst_playing", int'(playing_o), 1);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (bird_row_o == 3'd6) found = 1'b1;
      else begin key = ~key; step(); end
    end
    key = 1'b0;
    chk("reach_row6", int'(found), 1);
    #3; rst_n = 1'b0; #1;
    chk("mid_rst_playing", int'(playing_o), 0);
    chk("mid_rst_row", int'(bird_row_o), 4);
    chk("mid_rst_score", int'(score_o), 0);
    chk("mid_rst_clr", int'(bounds_clr_o), 1);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
